fft16_seq_ctrl: RTL and testbench

Frame sequencer for the 16-point FFT datapath (input buffer + radix-2 butterfly stages).
- Accepts a stream of 16 real samples over a valid/ready handshake and writes them into the input buffer.
- Steps the four butterfly stages with per-stage enable strobes, then streams the 16 results out over a second valid/ready handshake.
- Sits between the sample source and the FFT top; it owns all buffer write and stage-sequencing control.

---
 rtl/fft16_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_fft16_seq_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fft16_seq_ctrl.sv
// fft16_seq_ctrl: frame sequencer for the 16-point FFT datapath.
// Loads 16 samples into the input buffer, strobes the four butterfly
// stages (STAGE_CYCLES cycles each), then streams 16 result indices out.
// Optional build macro FFT16_SEQ_BITREV_EN: result index is bit-reversed
// so a DIT datapath emerges in natural frequency order.
module fft16_seq_ctrl #(
   parameter int WIDTH        = 16,
   parameter int N            = 16,
   parameter int STAGE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             buf_load,
   output logic [3:0]       buf_addr,
   output logic [WIDTH-1:0] buf_data,
   output logic             stage_en,
   output logic [1:0]       stage_idx,
   output logic [3:0]       rd_addr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             frame_done
);

   localparam logic [3:0] LAST_IDX = 4'(N - 1);
   localparam logic [3:0] CYC_LAST = 4'(STAGE_CYCLES - 1);

   typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

   state_t     r_state, w_state_n;
   logic [3:0] r_cnt, w_cnt_n;
   logic [1:0] r_stage, w_stage_n;
   logic [3:0] r_cyc, w_cyc_n;
   logic       r_done, w_done_n;
   logic [3:0] w_rd_idx;

   // Result index mapping: identity or bit-reverse of the result counter.
`ifdef FFT16_SEQ_BITREV_EN
   assign w_rd_idx = {r_cnt[0], r_cnt[1], r_cnt[2], r_cnt[3]};
`else
   assign w_rd_idx = r_cnt;
`endif

   // Sample data goes straight through to the buffer write port.
   assign buf_data   = in_data;
   assign frame_done = r_done;

   // State and counter registers; reset discards any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= LOAD;
         r_cnt   <= '0;
         r_stage <= '0;
         r_cyc   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_stage <= w_stage_n;
         r_cyc   <= w_cyc_n;
         r_done  <= w_done_n;
      end
   end

   // Next-state, counter updates and handshake/strobe outputs.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_stage_n = r_stage;
      w_cyc_n   = r_cyc;
      w_done_n  = 1'b0;
      in_ready  = 1'b0;
      buf_load  = 1'b0;
      buf_addr  = '0;
      stage_en  = 1'b0;
      stage_idx = '0;
      rd_addr   = '0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (r_state)
         LOAD: begin
            in_ready = 1'b1;
            buf_addr = r_cnt;
            if (in_valid) begin
               buf_load = 1'b1;
               w_cnt_n  = r_cnt + 4'd1;
               if (r_cnt == LAST_IDX) begin
                  w_cnt_n   = '0;
                  w_cyc_n   = '0;
                  w_stage_n = '0;
                  w_state_n = COMPUTE;
               end
            end
         end
         COMPUTE: begin
            busy      = 1'b1;
            stage_idx = r_stage;
            stage_en  = (r_cyc == 4'd0);
            if (r_cyc == CYC_LAST) begin
               w_cyc_n   = '0;
               w_stage_n = r_stage + 2'd1;
               if (r_stage == 2'd3) w_state_n = UNLOAD;
            end else begin
               w_cyc_n = r_cyc + 4'd1;
            end
         end
         UNLOAD: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            rd_addr   = w_rd_idx;
            if (out_ready) begin
               w_cnt_n = r_cnt + 4'd1;
               if (r_cnt == LAST_IDX) begin
                  w_cnt_n   = '0;
                  w_done_n  = 1'b1;
                  w_state_n = LOAD;
               end
            end
         end
         default: w_state_n = LOAD;
      endcase
      // Reset holds every handshake and strobe output quiet.
      if (rst) begin
         in_ready  = 1'b0;
         buf_load  = 1'b0;
         buf_addr  = '0;
         stage_en  = 1'b0;
         stage_idx = '0;
         rd_addr   = '0;
         out_valid = 1'b0;
         busy      = 1'b0;
      end
   end

endmodule

// File: tb/tb_fft16_seq_ctrl.sv
// Bench for fft16_seq_ctrl: two instances (STAGE_CYCLES=2 and 1) share
// stimulus; each is checked against a frame-level timeline model.
module tb_fft16_seq_ctrl;
   localparam int W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, in_valid, out_ready;
   logic [W-1:0] in_data;

   logic         in_ready_w  [2];
   logic         buf_load_w  [2];
   logic [3:0]   buf_addr_w  [2];
   logic [W-1:0] buf_data_w  [2];
   logic         stage_en_w  [2];
   logic [1:0]   stage_idx_w [2];
   logic [3:0]   rd_addr_w   [2];
   logic         out_valid_w [2];
   logic         busy_w      [2];
   logic         frame_done_w[2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      fft16_seq_ctrl #(.WIDTH(W), .N(16), .STAGE_CYCLES(g == 0 ? 2 : 1)) u_dut (
         .clk(clk), .rst(rst),
         .in_valid(in_valid), .in_ready(in_ready_w[g]), .in_data(in_data),
         .buf_load(buf_load_w[g]), .buf_addr(buf_addr_w[g]), .buf_data(buf_data_w[g]),
         .stage_en(stage_en_w[g]), .stage_idx(stage_idx_w[g]),
         .rd_addr(rd_addr_w[g]), .out_valid(out_valid_w[g]), .out_ready(out_ready),
         .busy(busy_w[g]), .frame_done(frame_done_w[g])
      );
   end

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Model: samples written this frame, results accepted, cycle of 16th accept.
   int m_wr[2], m_rd[2], m_T[2];
   bit m_done[2];

   function automatic logic [3:0] f_rd(int n);
      logic [3:0] a;
      a = 4'(n);
`ifdef FFT16_SEQ_BITREV_EN
      return {a[0], a[1], a[2], a[3]};
`else
      return a;
`endif
   endfunction

   task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d t=%0d: got %0h expected %0h", tag, d, cyc, obs, exp);
      end
   endtask

   task automatic step(bit r, bit iv, logic [W-1:0] dat, bit ordy);
      rst = r; in_valid = iv; in_data = dat; out_ready = ordy;
      #2;
      for (int d = 0; d < 2; d++) begin
         int  s, k;
         bit  ld, cp, ul;
         s  = (d == 0) ? 2 : 1;
         k  = cyc - m_T[d] - 1;
         ld = (m_wr[d] < 16);
         cp = !ld && (k < 4 * s);
         ul = !ld && !cp;
         if (r) begin
            chk("rst_in_ready", d, 32'(in_ready_w[d]), 0);
            chk("rst_buf_load", d, 32'(buf_load_w[d]), 0);
            chk("rst_buf_addr", d, 32'(buf_addr_w[d]), 0);
            chk("rst_stage_en", d, 32'(stage_en_w[d]), 0);
            chk("rst_stage_idx", d, 32'(stage_idx_w[d]), 0);
            chk("rst_rd_addr", d, 32'(rd_addr_w[d]), 0);
            chk("rst_out_valid", d, 32'(out_valid_w[d]), 0);
            chk("rst_busy", d, 32'(busy_w[d]), 0);
         end else begin
            chk("in_ready", d, 32'(in_ready_w[d]), 32'(ld));
            chk("buf_load", d, 32'(buf_load_w[d]), 32'(ld && iv));
            if (ld && iv) begin
               chk("buf_addr", d, 32'(buf_addr_w[d]), 32'(m_wr[d]));
               chk("buf_data", d, 32'(buf_data_w[d]), 32'(dat));
            end
            chk("stage_en", d, 32'(stage_en_w[d]), 32'(cp && (k % s == 0)));
            if (cp) chk("stage_idx", d, 32'(stage_idx_w[d]), 32'(k / s));
            chk("out_valid", d, 32'(out_valid_w[d]), 32'(ul));
            if (ul) chk("rd_addr", d, 32'(rd_addr_w[d]), 32'(f_rd(m_rd[d])));
            chk("busy", d, 32'(busy_w[d]), 32'(!ld));
         end
         chk("frame_done", d, 32'(frame_done_w[d]), 32'(m_done[d]));
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         int  s, k;
         bit  ld, ul, dn;
         s  = (d == 0) ? 2 : 1;
         k  = cyc - m_T[d] - 1;
         ld = (m_wr[d] < 16);
         ul = !ld && (k >= 4 * s);
         dn = 1'b0;
         if (r) begin
            m_wr[d] = 0;
            m_rd[d] = 0;
         end else if (ld && iv) begin
            m_wr[d]++;
            if (m_wr[d] == 16) m_T[d] = cyc;
         end else if (ul && ordy) begin
            m_rd[d]++;
            if (m_rd[d] == 16) begin
               m_wr[d] = 0;
               m_rd[d] = 0;
               dn = 1'b1;
            end
         end
         m_done[d] = dn;
      end
      cyc++;
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_wr[d] = 0; m_rd[d] = 0; m_T[d] = 0; m_done[d] = 1'b0;
      end
      @(posedge clk);
      cyc++;
      #1;
      step(1, 0, '0, 0);

      // Frame 1: samples 1..16 back to back, sink stalls 3 cycles into UNLOAD.
      for (int i = 0; i < 16; i++) step(0, 1, W'(i + 1), 1);
      for (int i = 0; i < 11; i++) step(0, 1, 16'hdead, 0);
      for (int i = 0; i < 17; i++) step(0, 0, '0, 1);

      // Frame 2: in_valid alternates, then random sink backpressure.
      for (int i = 0; i < 32; i++) step(0, (i % 2) == 0, W'($urandom), 0);
      for (int i = 0; i < 40; i++) step(0, 0, '0, 1'($urandom));
      for (int i = 0; i < 100 && (m_wr[0] != 0 || m_wr[1] != 0); i++) step(0, 0, '0, 1);

      // Reset on the second COMPUTE cycle; next sample must land at address 0.
      for (int i = 0; i < 16; i++) step(0, 1, W'($urandom), 1);
      step(0, 0, '0, 1);
      step(1, 0, '0, 1);
      step(0, 1, 16'h0055, 0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 500; i++)
         step(($urandom_range(0, 99) == 0), 1'($urandom), W'($urandom), 1'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
